muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS core's execute stage, owning the architectural HI/LO registers. It runs MULT, MULTU, DIV and DIVU over N+1 cycles with a start/busy/done handshake, and services MTHI/MTLO writes. Its `hi`/`lo` outputs feed the N-bit 2:1 writeback muxes that choose between ALU result and HI/LO for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit that owns the architectural HI/LO
// registers. MULT/MULTU use shift-add and DIV/DIVU use restoring division, one
// bit per cycle. Every operation takes N+1 busy cycles and ends with a one-cycle
// done pulse. MTHI/MTLO writes are accepted only while the unit is idle.
//
// Build option: define MULDIV_DIV_EN to include the divide datapath. Without
// it, a start with op[1]=1 is ignored.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start, op       launch (sampled when idle); 00 MULTU 01 MULT 10 DIVU 11 DIV
//   a, b            multiplicand/dividend (rs), multiplier/divisor (rt)
//   hi_we, lo_we    MTHI / MTLO write enables, with data on wdata
//   busy, done      operation in progress / one-cycle result-valid pulse
//   hi, lo          HI / LO registers
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / developing quotient}.
  logic [2*N-1:0]   work_q, work_d;
  logic [N-1:0]     opd_q, opd_d;      // multiplicand or divisor magnitude
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N-1:0]     hi_q, hi_d;
  logic [N-1:0]     lo_q, lo_d;

  logic [N-1:0]     a_mag, b_mag;
  logic             accept;
  logic [N:0]       mul_sum;
  logic [2*N-1:0]   mul_prod;

  assign a_mag   = (op[0] && a[N-1]) ? -a : a;
  assign b_mag   = (op[0] && b[N-1]) ? -b : b;
  assign mul_sum = {1'b0, work_q[2*N-1:N]} + (work_q[0] ? {1'b0, opd_q} : '0);
  assign mul_prod = (neg_a_q ^ neg_b_q) ? -work_q : work_q;

`ifdef MULDIV_DIV_EN
  logic             is_div_q, is_div_d;
  logic             bzero_q, bzero_d;
  logic [N:0]       div_part;
  logic             div_ge;
  logic [N-1:0]     div_rem;
  logic [N-1:0]     quo_fix, rem_fix;

  assign accept   = start;
  assign div_part = {work_q[2*N-1:N], work_q[N-1]};
  assign div_ge   = div_part >= {1'b0, opd_q};
  // The difference always fits in N bits when div_ge holds.
  assign div_rem  = div_ge ? (div_part[N-1:0] - opd_q) : div_part[N-1:0];
  // Divide by zero leaves the dividend magnitude as the remainder. After the
  // sign fix this reproduces a exactly, so only LO needs forcing.
  assign quo_fix  = bzero_q ? '1 :
                    ((neg_a_q ^ neg_b_q) ? -work_q[N-1:0] : work_q[N-1:0]);
  assign rem_fix  = neg_a_q ? -work_q[2*N-1:N] : work_q[2*N-1:N];
`else
  assign accept   = start && !op[1];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    opd_d   = opd_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
    is_div_d = is_div_q;
    bzero_d  = bzero_q;
`endif
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (accept) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          neg_a_d = op[0] & a[N-1];
          neg_b_d = op[0] & b[N-1];
          work_d  = {{N{1'b0}}, b_mag};
          opd_d   = a_mag;
`ifdef MULDIV_DIV_EN
          is_div_d = op[1];
          bzero_d  = (b == '0);
          if (op[1]) begin
            work_d = {{N{1'b0}}, a_mag};
            opd_d  = b_mag;
          end
`endif
        end
      end
      RUN: begin
        cnt_d  = cnt_q + 1'b1;
        work_d = {mul_sum, work_q[N-1:1]};
`ifdef MULDIV_DIV_EN
        if (is_div_q) work_d = {div_rem, work_q[N-2:0], div_ge};
`endif
        if (cnt_q == CW'(N - 1)) state_d = FIX;
      end
      FIX: begin
        hi_d = mul_prod[2*N-1:N];
        lo_d = mul_prod[N-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
`endif
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      opd_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      bzero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      opd_q   <= opd_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
      is_div_q <= is_div_d;
      bzero_q  <= bzero_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a, b, wdata;
  logic         hi_we, lo_we;
  logic         busy, done;
  logic [N-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  int inj_k = -1;
  bit mt_at_start = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: result {HI, LO} straight from architectural arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic signed [31:0] dx, dy, q, r;
    case (o)
      2'b00: return {32'b0, x} * {32'b0, y};
      2'b01: begin
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        return sx * sy;
      end
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        dx = x;
        dy = y;
        q = dx / dy;
        r = dx % dy;
        return {r, q};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {63'b0, done}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("hi", {32'b0, hi}, {32'b0, e[63:32]});
          check("lo", {32'b0, lo}, {32'b0, e[31:0]});
        end
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bit acc;
    int g;
    int bad;
    logic [N-1:0] hi0, lo0, hib, lob;
`ifdef MULDIV_DIV_EN
    acc = 1'b1;
`else
    acc = !o[1];
`endif
    g = 0;
    while (busy !== 1'b0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (busy !== 1'b0) check("idle_timeout", {63'b0, busy}, 64'd0);
    @(negedge clk);
    hi0 = hi;
    lo0 = lo;
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    if (mt_at_start) begin
      hi_we = 1'b1;
      wdata = 32'h1234_5678;
    end
    if (acc) exp_q.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    b = $urandom;
    if (!acc) begin
      bad = 0;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) begin
          @(posedge clk);
          #1;
        end
        if (busy !== 1'b0 || done !== 1'b0) bad++;
      end
      check("div_ignored_handshake", bad, 0);
      check("div_ignored_hilo", {hi, lo}, {hi0, lo0});
      return;
    end
    if (mt_at_start) check("mthi_with_start", {32'b0, hi}, {32'b0, 32'h1234_5678});
    hib = hi;
    lob = lo;
    bad = 0;
    for (int k = 0; k <= N + 1; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == inj_k) begin
        start = 1'b1;
        op = 2'b00;
        a = 32'd2;
        b = 32'd3;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_DEAD;
      end else if (inj_k >= 0 && k == inj_k + 1) begin
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mt_while_busy", {hi, lo}, {hib, lob});
      end
      if (k <= N) begin
        if (busy !== 1'b1 || done !== 1'b0) bad++;
      end else begin
        if (busy !== 1'b0 || done !== 1'b1) bad++;
      end
    end
    check("latency", bad, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    #1;
    check("reset_flags", {62'b0, busy, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'd100, 32'd7);
    run_op(2'b10, 32'h64, 32'h0);
    run_op(2'b11, 32'hFFFF_FF00, 32'h0);

    inj_k = 5;
    run_op(2'b00, 32'd7, 32'd9);
    inj_k = -1;

    // MTHI / MTLO in idle.
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h0000_DEAD;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    check("mthi_idle", {32'b0, hi}, {32'b0, 32'h0000_DEAD});
    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'hBEEF_0001;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    check("mtlo_idle", {hi, lo}, {32'h0000_DEAD, 32'hBEEF_0001});

    mt_at_start = 1'b1;
    run_op(2'b01, 32'd1234, 32'hFFFF_FF00);
    mt_at_start = 1'b0;

    // Reset in the middle of a MULTU: no result, no done.
    @(negedge clk);
    op = 2'b00;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_flags", {62'b0, busy, done}, 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (N + 5) @(posedge clk);
    #1;
    run_op(2'b00, 32'd123456, 32'd789);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick(), pick());
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
